// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW interlock: per-register write countdowns, drain flag and stall counter.
// Stall/issue are combinational from the counters; stall holds decode until the operand is bypassable.
module hazard_scoreboard #(
  parameter int NREG = 8,
  parameter int LAT  = 4,
  parameter int CW   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] src1_sel,
  input  logic                    src1_used,
  input  logic [$clog2(NREG)-1:0] src2_sel,
  input  logic                    src2_used,
  input  logic [$clog2(NREG)-1:0] dst_sel,
  input  logic                    dst_write,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issue,
  output logic                    drained,
  output logic [NREG-1:0]         pending,
  output logic [15:0]             stall_count
);

  localparam int SW = $clog2(NREG);

  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] w_cnt_nxt [NREG];
  logic          r_drained;
  logic [15:0]   r_stall_count;
  logic          w_hazard;
  logic          w_stall;
  logic          w_go;
  logic          w_idle_nxt;

  // A count of 1 means the write lands this cycle and is bypassed, so only >=2 interlocks.
  always_comb begin
    w_hazard = (src1_used && (r_cnt[src1_sel] >= CW'(2))) ||
               (src2_used && (r_cnt[src2_sel] >= CW'(2)));
    w_stall  = id_valid && !flush && w_hazard;
    w_go     = id_valid && !flush && !w_hazard;
  end

  // Outputs are forced quiet while reset is held; state is already cleared by then.
  assign stall       = rst & w_stall;
  assign issue       = rst & w_go;
  assign drained     = r_drained;
  assign stall_count = r_stall_count;

  always_comb begin
    pending    = '0;
    w_idle_nxt = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      pending[r] = |r_cnt[r];
      if (w_go && dst_write && (dst_sel == SW'(r)))
        w_cnt_nxt[r] = CW'(LAT);
      else if (|r_cnt[r])
        w_cnt_nxt[r] = r_cnt[r] - CW'(1);
      else
        w_cnt_nxt[r] = '0;
      w_idle_nxt = w_idle_nxt && (w_cnt_nxt[r] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_drained     <= 1'b1;
      r_stall_count <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_drained <= w_idle_nxt;
      if (w_stall && !(&r_stall_count))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus multi-cycle corner sequences.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  src1_sel;
  logic        src1_used;
  logic [2:0]  src2_sel;
  logic        src2_used;
  logic [2:0]  dst_sel;
  logic        dst_write;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        drained;
  logic [7:0]  pending;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1_sel(src1_sel), .src1_used(src1_used),
    .src2_sel(src2_sel), .src2_used(src2_used),
    .dst_sel(dst_sel), .dst_write(dst_write), .flush(flush),
    .stall(stall), .issue(issue), .drained(drained),
    .pending(pending), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] d;
    logic       dw;
    logic       fl;
    logic       e_stall;
    logic       e_issue;
    logic       e_drained;
    logic [7:0] e_pend;
    logic [15:0] e_sc;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2, input logic [2:0] d,
                       input logic dw, input logic fl);
    id_valid = vld; src1_sel = s1; src1_used = u1; src2_sel = s2;
    src2_used = u2; dst_sel = d; dst_write = dw; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all(input string tag, input logic e_st, input logic e_is,
                           input logic e_dr, input logic [7:0] e_pd, input logic [15:0] e_sc);
    chk({tag, ".stall"},       32'(stall),       32'(e_st));
    chk({tag, ".issue"},       32'(issue),       32'(e_is));
    chk({tag, ".drained"},     32'(drained),     32'(e_dr));
    chk({tag, ".pending"},     32'(pending),     32'(e_pd));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(e_sc));
  endtask

  function automatic vec_t mk(input logic vld, input logic [2:0] s1, input logic u1,
                              input logic [2:0] s2, input logic u2, input logic [2:0] d,
                              input logic dw, input logic fl, input logic es, input logic ei,
                              input logic ed, input logic [7:0] ep, input logic [15:0] esc);
    vec_t v;
    v = '{vld, s1, u1, s2, u2, d, dw, fl, es, ei, ed, ep, esc};
    return v;
  endfunction

  initial begin
    // Dependent pair on r1
    tbl.push_back(mk(1,0,0,0,0,1,1,0, 0,1,1,8'h00,0));
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 1,0,0,8'h02,0));
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 1,0,0,8'h02,1));
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 1,0,0,8'h02,2));
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 0,1,0,8'h02,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,8'h00,3));
    // Independent stream writing r2, then an unused src2 naming r2
    tbl.push_back(mk(1,3,1,4,1,2,1,0, 0,1,1,8'h00,3));
    tbl.push_back(mk(1,3,1,4,1,2,1,0, 0,1,0,8'h04,3));
    tbl.push_back(mk(1,3,1,4,1,2,1,0, 0,1,0,8'h04,3));
    tbl.push_back(mk(1,3,1,2,0,0,0,0, 0,1,0,8'h04,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,8'h04,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,8'h04,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,8'h04,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,8'h00,3));
    // Flushed write to r5 never loads; following read issues
    tbl.push_back(mk(1,0,0,0,0,5,1,1, 0,0,1,8'h00,3));
    tbl.push_back(mk(1,5,1,0,0,0,0,0, 0,1,1,8'h00,3));
    // Flushed reader does not stall; stalled writer to r6 does not load
    tbl.push_back(mk(1,0,0,0,0,5,1,0, 0,1,1,8'h00,3));
    tbl.push_back(mk(1,5,1,0,0,0,0,1, 0,0,0,8'h20,3));
    tbl.push_back(mk(1,5,1,0,0,6,1,0, 1,0,0,8'h20,3));
    tbl.push_back(mk(1,5,1,0,0,6,1,0, 1,0,0,8'h20,4));
    tbl.push_back(mk(1,5,1,0,0,6,1,0, 0,1,0,8'h20,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,8'h40,5));
    // Self-dependent instruction (reads and writes r0) issues; later src2 read stalls
    tbl.push_back(mk(1,0,1,0,0,0,1,0, 0,1,0,8'h40,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,8'h41,5));
    tbl.push_back(mk(1,0,0,0,1,0,0,0, 1,0,0,8'h41,5));
    tbl.push_back(mk(1,0,0,0,1,0,0,0, 1,0,0,8'h01,6));
    tbl.push_back(mk(1,0,0,0,1,0,0,0, 0,1,0,8'h01,7));
    // Invalid instruction with dst_write does not load
    tbl.push_back(mk(0,0,0,0,0,3,1,0, 0,0,1,8'h00,7));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,8'h00,7));

    // Reset held with random inputs
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check_all($sformatf("reset%0d", i), 0, 0, 1, 8'h00, 16'h0);
      @(posedge clk); #1;
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    check_all("released", 0, 0, 1, 8'h00, 16'h0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2,
            tbl[i].d, tbl[i].dw, tbl[i].fl);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_issue,
                tbl[i].e_drained, tbl[i].e_pend, tbl[i].e_sc);
      @(posedge clk); #1;
    end

    // WAW: second write to r6 two cycles later reloads the counter
    drive(1, 0, 0, 0, 0, 6, 1, 0);
    @(negedge clk); chk("waw.issue1", 32'(issue), 32'd1);
    @(posedge clk); #1;
    idle();
    @(negedge clk); chk("waw.pend1", 32'(pending), 32'h40);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 6, 1, 0);
    @(negedge clk); chk("waw.issue2", 32'(issue), 32'd1);
    @(posedge clk); #1;
    idle();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("waw.drained+%0d", k), 32'(drained), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("waw.pend+%0d", k), 32'(pending), (k == 5) ? 32'h00 : 32'h40);
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a stall
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rstmid.stall_before", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1 check_all("rstmid.async", 0, 0, 1, 8'h00, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all("rstmid.after", 0, 1, 1, 8'h00, 16'h0);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;

    // Saturation: self-dependent r1 instruction stalls 3 of every 4 cycles
    drive(1, 1, 1, 0, 0, 1, 1, 0);
    repeat (4000) @(posedge clk);
    @(negedge clk);
    chk("sat.mid", 32'(stall_count), 32'd3000);
    repeat (83387) @(posedge clk);
    @(negedge clk);
    chk("sat.hold", 32'(stall_count), 32'hFFFF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
